// File: rtl/challenge_sequencer_if.sv
// CRP output channel of the challenge sequencer: valid/ready plus payload.
interface challenge_sequencer_if #(
  parameter int CW = 3
);
  logic          crp_valid;
  logic          crp_ready;
  logic [CW-1:0] crp_chal;
  logic          crp_resp;
  logic [2:0]    crp_ones;

  modport master (
    output crp_valid,
    output crp_chal,
    output crp_resp,
    output crp_ones,
    input  crp_ready
  );

  modport slave (
    input  crp_valid,
    input  crp_chal,
    input  crp_resp,
    input  crp_ones,
    output crp_ready
  );
endinterface

// File: rtl/challenge_sequencer.sv
// Challenge sequencer: sweeps C over NUM_CRP values, samples the PUF response
// REPEATS times per challenge after a settle window, and emits a
// majority-voted CRP on a valid/ready channel.
module challenge_sequencer #(
  parameter int CW            = 3,
  parameter int SETTLE_CYCLES = 16,
  parameter int REPEATS       = 5,
  parameter int NUM_CRP       = 8
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic                      start,
  output logic [CW-1:0]             C,
  input  logic                      resp_in,
  challenge_sequencer_if.master     crp,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    timer_q, timer_d;
  logic [2:0]    rep_q, rep_d;
  logic [2:0]    ones_q, ones_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] c_q, c_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] chal_q, chal_d;
  logic          resp_q, resp_d;
  logic [2:0]    onesout_q, onesout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [2:0]    ones_upd;

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    rep_d     = rep_q;
    ones_d    = ones_q;
    idx_d     = idx_q;
    c_d       = c_q;
    valid_d   = valid_q;
    chal_d    = chal_q;
    resp_d    = resp_q;
    onesout_d = onesout_q;
    ones_upd  = ones_q + {2'b00, resp_in};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          c_d     = '0;
          idx_d   = '0;
          ones_d  = '0;
          rep_d   = '0;
          timer_d = '0;
        end
      end
      S_SETTLE: begin
        timer_d = timer_q + 8'd1;
        if (timer_q == 8'(SETTLE_CYCLES - 1)) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        ones_d = ones_upd;
        rep_d  = rep_q + 3'd1;
        if (rep_q == 3'(REPEATS - 1)) begin
          state_d   = S_EMIT;
          valid_d   = 1'b1;
          chal_d    = c_q;
          onesout_d = ones_upd;
          resp_d    = (ones_upd > 3'(REPEATS / 2));
        end else begin
          timer_d = '0;
          state_d = S_SETTLE;
        end
      end
      S_EMIT: begin
        if (crp.crp_ready) begin
          valid_d = 1'b0;
          if (idx_q == CW'(NUM_CRP - 1)) begin
            state_d = S_DONE;
          end else begin
            // C advances only here, so each challenge gets a full settle window.
            idx_d   = idx_q + 1'b1;
            c_d     = c_q + 1'b1;
            ones_d  = '0;
            rep_d   = '0;
            timer_d = '0;
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; clear wins over everything.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      rep_q     <= '0;
      ones_q    <= '0;
      idx_q     <= '0;
      c_q       <= '0;
      valid_q   <= 1'b0;
      chal_q    <= '0;
      resp_q    <= 1'b0;
      onesout_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      rep_q     <= rep_d;
      ones_q    <= ones_d;
      idx_q     <= idx_d;
      c_q       <= c_d;
      valid_q   <= valid_d;
      chal_q    <= chal_d;
      resp_q    <= resp_d;
      onesout_q <= onesout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign C             = c_q;
  assign crp.crp_valid = valid_q;
  assign crp.crp_chal  = chal_q;
  assign crp.crp_resp  = resp_q;
  assign crp.crp_ones  = onesout_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
